// File: rtl/ram8_arbiter_if.sv
// Requester/RAM bundle for ram8_arbiter.
// It carries two request ports, the response signals and the ram8 pin group.
// The slave modport is the arbiter's view. The master modport is the
// requester and RAM side.
interface ram8_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             req0, we0, ack0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] wdata0;
  logic             req1, we1, ack1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] wdata1;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic [WIDTH-1:0] ram_in;
  logic             ram_load;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_out;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
    output ack0, ack1, rdata, busy, ram_in, ram_load, ram_address
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
    input  ack0, ack1, rdata, busy, ram_in, ram_load, ram_address
  );
endinterface

// File: rtl/ram8_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single ram8.
// Each transaction runs IDLE -> ACCESS -> RESP, and every output is registered.
// A write returns the pre-write word in rdata, which makes it read-before-write.
// Optional: define RAM8_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module ram8_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  ram8_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] ram_in_q, ram_in_d;
  logic             ram_load_q, ram_load_d;
  logic [AW-1:0]    ram_address_q, ram_address_d;

  // Next-state and next-output logic. Requests are looked at only in IDLE.
  always_comb begin
    logic win;
    win           = 1'b0;
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    ack0_d        = ack0_q;
    ack1_d        = ack1_q;
    busy_d        = busy_q;
    rdata_d       = rdata_q;
    ram_in_d      = ram_in_q;
    ram_load_d    = ram_load_q;
    ram_address_d = ram_address_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
`ifdef RAM8_ARB_FIXED_PRIO_EN
          win = !bus.req0;
`else
          // On a tie, the port that did not win last time goes first.
          win = (bus.req0 && bus.req1) ? !last_grant_q : bus.req1;
`endif
          state_d       = ACCESS;
          busy_d        = 1'b1;
          last_grant_d  = win;
          grant_d       = win;
          ram_address_d = win ? bus.addr1  : bus.addr0;
          ram_in_d      = win ? bus.wdata1 : bus.wdata0;
          ram_load_d    = win ? bus.we1    : bus.we0;
        end
      end
      ACCESS: begin
        // The ram8 commits the write on this same edge.
        // rdata therefore captures the old contents.
        rdata_d    = bus.ram_out;
        ram_load_d = 1'b0;
        ack0_d     = !grant_q;
        ack1_d     = grant_q;
        state_d    = RESP;
      end
      RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      busy_q        <= 1'b0;
      rdata_q       <= '0;
      ram_in_q      <= '0;
      ram_load_q    <= 1'b0;
      ram_address_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      busy_q        <= busy_d;
      rdata_q       <= rdata_d;
      ram_in_q      <= ram_in_d;
      ram_load_q    <= ram_load_d;
      ram_address_q <= ram_address_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.busy        = busy_q;
  assign bus.rdata       = rdata_q;
  assign bus.ram_in      = ram_in_q;
  assign bus.ram_load    = ram_load_q;
  assign bus.ram_address = ram_address_q;
endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter. It includes a behavioral ram8 model
// (combinational read, write on the clock edge when load is high).
module tb_ram8_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;
  logic [15:0] mem [8];

  ram8_arbiter_if #(.WIDTH(16), .AW(3)) bus ();

  ram8_arbiter #(.WIDTH(16), .AW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // ram8 model
  assign bus.ram_out = mem[bus.ram_address];
  always @(posedge clk) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_g;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    mem[5] = 16'h00AA;
    reset = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    tick(); tick();
    // reset state
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_load", bus.ram_load, 0);
    chk("rst_addr", bus.ram_address, 0);
    chk("rst_in", bus.ram_in, 0);
    @(negedge clk) reset = 1'b0;

    // port0 write addr3 BEEF
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3; bus.wdata0 = 16'hBEEF;
    tick();
    chk("w1_load", bus.ram_load, 1);
    chk("w1_addr", bus.ram_address, 3);
    chk("w1_in", bus.ram_in, 16'hBEEF);
    chk("w1_busy", bus.busy, 1);
    chk("w1_noack", bus.ack0, 0);
    bus.req0 = 0;
    tick();
    chk("w1_ack0", bus.ack0, 1);
    chk("w1_ack1", bus.ack1, 0);
    chk("w1_load_off", bus.ram_load, 0);
    chk("w1_mem3", mem[3], 16'hBEEF);
    chk("w1_rdata_old", bus.rdata, 16'h0000);
    tick();
    chk("w1_ack_drop", bus.ack0, 0);
    chk("w1_idle", bus.busy, 0);

    // port1 read addr3
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3;
    tick();
    chk("r1_load", bus.ram_load, 0);
    chk("r1_busy", bus.busy, 1);
    tick();
    chk("r1_ack1", bus.ack1, 1);
    chk("r1_ack0", bus.ack0, 0);
    chk("r1_rdata", bus.rdata, 16'hBEEF);
    chk("r1_load2", bus.ram_load, 0);
    bus.req1 = 0;
    tick();
    chk("r1_ack_drop", bus.ack1, 0);

    // port0 write addr5 1234 over 00AA: read-before-write
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5; bus.wdata0 = 16'h1234;
    tick();
    chk("w2_load", bus.ram_load, 1);
    tick();
    chk("w2_ack0", bus.ack0, 1);
    chk("w2_rbw", bus.rdata, 16'h00AA);
    bus.req0 = 0;
    tick();
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5;
    tick(); tick();
    chk("r2_ack1", bus.ack1, 1);
    chk("r2_rdata", bus.rdata, 16'h1234);
    bus.req1 = 0;
    tick();

    // both ports held: alternate (or port0 always under fixed priority)
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5;
    exp_g = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("alt_busy", bus.busy, 1);
      chk("alt_noack", {bus.ack0, bus.ack1}, 0);
      tick();
      chk("alt_ack0", bus.ack0, !exp_g);
      chk("alt_ack1", bus.ack1, exp_g);
      chk("alt_rdata", bus.rdata, exp_g ? 16'h1234 : 16'hBEEF);
      tick();
      chk("alt_ackoff", {bus.ack0, bus.ack1}, 0);
`ifndef RAM8_ARB_FIXED_PRIO_EN
      exp_g = !exp_g;
`endif
    end
    bus.req0 = 0; bus.req1 = 0;
    tick(); tick();

    // reset during ACCESS of write FFFF to addr2
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2; bus.wdata0 = 16'hFFFF;
    tick();
    chk("rw_load", bus.ram_load, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_load_drop", bus.ram_load, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_addr", bus.ram_address, 0);
    bus.req0 = 0;
    tick();
    chk("rw_mem2", mem[2], 16'h0000);
    chk("rw_noack", {bus.ack0, bus.ack1}, 0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("rw_noack2", {bus.ack0, bus.ack1}, 0);

    // normal service after reset
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3;
    tick(); tick();
    chk("post_ack1", bus.ack1, 1);
    chk("post_rdata", bus.rdata, 16'hBEEF);
    bus.req1 = 0;
    tick();
    chk("post_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
